// File: rtl/octave_downsample.sv
// Halves an octave's Gaussian stream in both dimensions, either by 2x2 box
// averaging or top-left subsampling. Blanking samples pass through 1:1.
module octave_downsample #(
    parameter int width   = 420,
    parameter int average = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       validin,
    input  logic       blanking_in,
    output logic [7:0] dout,
    output logic       validout,
    output logic       blanking_out,
    output logic       short_row
);
    localparam int CW = $clog2(width);
    localparam int IW = CW - 1;

    logic [CW-1:0] col_q, col_d;
    logic          row_odd_q, row_odd_d;
    logic [7:0]    pair_q, pair_d;
    logic [7:0]    dout_q, dout_d;
    logic          validout_q, validout_d;
    logic          blanking_out_q, blanking_out_d;
    logic          short_row_q, short_row_d;

    logic          active, blank;
    logic [IW-1:0] idx;
    logic [7:0]    avg_pix;

    assign active = validin & ~blanking_in;
    assign blank  = validin & blanking_in;
    assign idx    = col_q[CW-1:1];

    if (average != 0) begin : g_avg
        logic [8:0]  lbuf [width/2];
        logic [8:0]  h;
        logic [10:0] sum;

        assign h       = {1'b0, pair_q} + {1'b0, din};
        // +2 before the shift gives round-half-up; the top value 1022>>2 fits 8 bits
        assign sum     = {2'b0, lbuf[idx]} + {2'b0, h} + 11'd2;
        assign avg_pix = sum[9:2];

        always_ff @(posedge clock) begin
            if (active && col_q[0] && !row_odd_q) lbuf[idx] <= h;
        end
    end else begin : g_sub
        assign avg_pix = '0;
    end

    always_comb begin
        col_d          = col_q;
        row_odd_d      = row_odd_q;
        pair_d         = pair_q;
        dout_d         = dout_q;
        validout_d     = 1'b0;
        blanking_out_d = blanking_out_q;
        short_row_d    = 1'b0;

        if (blank) begin
            col_d          = '0;
            row_odd_d      = 1'b0;
            dout_d         = '0;
            validout_d     = 1'b1;
            blanking_out_d = 1'b1;
            short_row_d    = (col_q != '0);
        end else if (active) begin
            if (!col_q[0]) pair_d = din;
            if (col_q == CW'(width - 1)) begin
                col_d     = '0;
                row_odd_d = ~row_odd_q;
            end else begin
                col_d = col_q + 1'b1;
            end
            if (average != 0) begin
                if (row_odd_q && col_q[0]) begin
                    dout_d         = avg_pix;
                    validout_d     = 1'b1;
                    blanking_out_d = 1'b0;
                end
            end else if (!row_odd_q && !col_q[0]) begin
                dout_d         = din;
                validout_d     = 1'b1;
                blanking_out_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col_q          <= '0;
            row_odd_q      <= 1'b0;
            pair_q         <= '0;
            dout_q         <= '0;
            validout_q     <= 1'b0;
            blanking_out_q <= 1'b1;
            short_row_q    <= 1'b0;
        end else begin
            col_q          <= col_d;
            row_odd_q      <= row_odd_d;
            pair_q         <= pair_d;
            dout_q         <= dout_d;
            validout_q     <= validout_d;
            blanking_out_q <= blanking_out_d;
            short_row_q    <= short_row_d;
        end
    end

    assign dout         = dout_q;
    assign validout     = validout_q;
    assign blanking_out = blanking_out_q;
    assign short_row    = short_row_q;
endmodule

// File: doc/octave_downsample.md
# octave_downsample

Decimates one octave's Gaussian stream by 2 in each dimension to produce the input stream for the next octave. It sits between an octave stage's `next_octave_dout/valid/blanking` outputs, which carry σ=1.60 at full width, and the following octave stage's `din/validin/blanking_in`, which expects half width. Blanking samples are forwarded 1:1 so the downstream 5x5 windows keep receiving their flush samples. It supports either plain subsampling or 2x2 box averaging.

## Interface
- `width`, 420: active pixels per input row. Must be even; output rows are `width/2`.
- `average`, 1: 1 selects 2x2 box average; 0 selects top-left subsample.

Ports:
- `clock`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `din`  in  8  input pixel.
- `validin`  in  1  sample present this cycle.
- `blanking_in`  in  1  with `validin`, marks a blanking (non-image) sample.
- `dout`  out  8  output pixel, registered.
- `validout`  out  1  output sample present, registered.
- `blanking_out`  out  1  output sample is blanking, registered.
- `short_row`  out  1  one-cycle pulse when blanking arrives mid-row.

## Operation
- Sample types:
  - Active sample = `validin & ~blanking_in`.
  - Blanking sample = `validin & blanking_in`.
  - `validin=0`: no state change, and `validout=0` next cycle.
- Counters:
  - `col` runs 0..width-1 on active samples and wraps to 0.
  - `row_odd` toggles on each wrap.
  - Both clear on reset and on any blanking sample, so the first active sample after blanking or reset is (row 0, col 0).
- Pair register (average mode): on even `col`, latch `din` into an 8-bit pair register. On odd `col`, form `h = pair + din` (9 bits).
- Line buffer (average mode): `width/2` entries × 9 bits, indexed by `col>>1`. Contents are not reset; every entry is written before it is read.
  - Even row, odd col: write `h` at index `col>>1`. No output.
  - Odd row, odd col: `sum = buf[col>>1] + h` (10 bits). Emit `dout = (sum + 2) >> 2`, i.e. round-half-up. Maximum (1020+2)>>2 = 255, so no saturation is needed.
- Subsample mode: emit `dout = din` for active samples with even row and even col. All others produce no output. No line buffer is instantiated (generate on `average`).
- Blanking forwarding: every blanking sample emits `validout=1`, `blanking_out=1`, `dout=0` next cycle.
- `short_row`: pulses 1 cycle (same cycle as the forwarded blanking) if `col != 0` when the blanking sample arrives.
  - The partial row is dropped.
  - In average mode an incomplete even row leaves stale buffer entries. These are overwritten before use, because the counters restart at row 0.
- Odd frame height: a trailing unpaired even row produces no output in either mode's odd-row path. In subsample mode it produces its even-row outputs normally.
- Output per frame: `width/2` active samples per output row, with `blanking_out=0`. Output rows = floor(H/2) in average mode, ceil(H/2) in subsample mode.

## Timing
- Reset values: `dout=0`, `validout=0`, `blanking_out=1`, `short_row=0`; `col=0`, `row_odd=0`, pair register = 0.
- Latency is 1 cycle, input edge to output register:
  - emitting active sample → output;
  - blanking sample → forwarded blanking.
- `validout` is high for exactly one cycle per emitted sample. There is no back-pressure; downstream must accept every sample.
- Maximum output rate:
  - average mode: 1 per 2 input cycles, only during odd rows;
  - subsample mode: 1 per 2 input cycles, only during even rows.
- Reset mid-frame: outputs go to reset values on the next edge. Any partial output in flight is discarded and no `short_row` is generated.
- Line buffer read is asynchronous or has same-cycle availability. If synchronous RAM is used, issue the read address on the even-col sample so the data is ready at the odd-col sample; external latency must stay 1.

## Test plan
- Average, width=8, 2 rows: row 0 = 0..7, row 1 = 8..15 → 4 outputs, `dout` = 5, 7, 9, 11 (e.g. (0+1+8+9+2)>>2=5), each 1 cycle after odd-col input, `blanking_out=0`.
- Average rounding: 2x2 block {1,1,1,0} (sum 3) → `dout=1`; block {255×4} → `dout=255`.
- Subsample, width=8: rows 0–3 ramp `din = 10*row + col` → outputs 0, 2, 4, 6, 20, 22, 24, 26; none during rows 1 and 3.
- Blanking mid-row: 3 active samples then 1 blanking → next cycle `validout=1`, `blanking_out=1`, `dout=0`, `short_row=1`. The following frame's first 2x2 block is computed correctly from fresh data.
- `validin` gaps: random 0–3 idle cycles inserted in the case-1 stimulus → identical output values and count, each still at 1-cycle latency.
- Reset asserted mid row 1, then a fresh frame → all outputs at reset values the cycle after reset. The new frame's output matches an uninterrupted run, with no `short_row` pulse.
